// File: rtl/mxint8_block_loader.sv
// Byte-serial to block-parallel MXINT8 assembler: one scale byte then BLOCK_SIZE
// element bytes per block, presented on a registered valid/ready output.
module mxint8_block_loader #(
  parameter int BLOCK_SIZE = 32,
  localparam int SCALE_WIDTH = 8,
  localparam int MXINT8_ELEMENT_WIDTH = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 i_valid,
  output logic                                                 o_ready,
  input  logic [7:0]                                           i_data,
  input  logic                                                 i_sof,
  output logic                                                 o_valid,
  input  logic                                                 i_ready,
  output logic [SCALE_WIDTH-1:0]                               o_scale,
  output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]      o_mxint8_elements,
  output logic                                                 o_frame_err
);

  localparam int CNT_W = $clog2(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t                                            state;
  state_t                                            state_next;
  logic [CNT_W-1:0]                                  cnt;
  logic [SCALE_WIDTH-1:0]                            shadow_scale;
  logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]   shadow_elems;
  logic                                              accept;
  logic                                              last_elem;
  logic                                              load;

  // Ready depends on state only, so no input reaches o_ready combinationally.
  assign o_ready   = (state != FULL);
  assign accept    = i_valid && o_ready;
  assign last_elem = (cnt == CNT_LAST);
  assign load      = (state == FULL) && (!o_valid || i_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && i_sof) state_next = COLLECT;
      COLLECT: if (accept && !i_sof && last_elem) state_next = FULL;
      FULL:    if (load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A scale byte always restarts the block; it is only an error mid-block,
  // while an element with no scale ahead of it is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      shadow_scale <= '0;
      shadow_elems <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      if (accept) begin
        if (i_sof) begin
          shadow_scale <= i_data;
          cnt          <= '0;
          if (state == COLLECT) o_frame_err <= 1'b1;
        end else if (state == COLLECT) begin
          shadow_elems[cnt] <= i_data;
          cnt               <= last_elem ? '0 : cnt + 1'b1;
        end else begin
          o_frame_err <= 1'b1;
        end
      end
    end
  end

  // A load in the same cycle as a downstream handshake keeps o_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid           <= 1'b0;
      o_scale           <= '0;
      o_mxint8_elements <= '0;
    end else if (load) begin
      o_valid           <= 1'b1;
      o_scale           <= shadow_scale;
      o_mxint8_elements <= shadow_elems;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
